// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: instruction field layout, widths,
// opcode encodings and the branch-wait state type.
package decode_stage_pkg;

    localparam int DEF_PC_WIDTH   = 16;
    localparam int DEF_IR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int REG_IDX_W      = 4;
    localparam int OPCODE_W       = 8;
    localparam int IMM_W          = 16;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 24;
    localparam int DEST_HI   = 23;
    localparam int DEST_LO   = 20;
    localparam int SRC1_HI   = 19;
    localparam int SRC1_LO   = 16;
    localparam int SRC2_HI   = 11;
    localparam int SRC2_LO   = 8;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 8'h00,
        OP_ADDI = 8'h01,
        OP_LDW  = 8'h40,
        OP_STW  = 8'h41,
        OP_BRZ  = 8'h80,
        OP_JMP  = 8'h90,
        OP_NOP  = 8'hFF
    } opcode_e;

    typedef enum logic {
        BR_IDLE,
        BR_WAIT
    } br_state_e;

endpackage

// File: rtl/decode_classify.sv
// Opcode classifier: which register fields an instruction reads/writes and
// whether it redirects control flow.
module decode_classify
    import decode_stage_pkg::*;
(
    input  logic [7:0] opcode,
    output logic       usesSrc1,
    output logic       usesSrc2,
    output logic       writesDest,
    output logic       isBranch
);

    always_comb begin
        usesSrc1   = 1'b0;
        usesSrc2   = 1'b0;
        writesDest = 1'b0;
        isBranch   = 1'b0;
        case (opcode)
            OP_ADD: begin
                usesSrc1   = 1'b1;
                usesSrc2   = 1'b1;
                writesDest = 1'b1;
            end
            OP_ADDI, OP_LDW: begin
                usesSrc1   = 1'b1;
                writesDest = 1'b1;
            end
            OP_STW: begin
                usesSrc1 = 1'b1;
                usesSrc2 = 1'b1;
            end
            OP_BRZ: begin
                usesSrc1 = 1'b1;
                isBranch = 1'b1;
            end
            OP_JMP: begin
                isBranch = 1'b1;
            end
            // OP_NOP and unknown encodings behave as bubbles for hazard purposes.
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register file read with writeback bypass, in-flight
// destination scoreboard, branch/dependency stalls and the DE/EX latch.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 16,
    parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int          PC_WIDTH   = DEF_PC_WIDTH,
    parameter int          IR_WIDTH   = DEF_IR_WIDTH
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET,
    input  logic                  I_LOCK,
    input  logic [PC_WIDTH-1:0]   I_PC,
    input  logic [IR_WIDTH-1:0]   I_IR,
    input  logic                  I_FetchStall,
    input  logic                  I_BranchAddrSelect,
    input  logic                  I_WBEnable,
    input  logic [3:0]            I_WBDestReg,
    input  logic [DATA_WIDTH-1:0] I_WBData,
    output logic                  O_LOCK,
    output logic [PC_WIDTH-1:0]   O_PC,
    output logic [7:0]            O_Opcode,
    output logic [3:0]            O_DestReg,
    output logic [DATA_WIDTH-1:0] O_Src1Value,
    output logic [DATA_WIDTH-1:0] O_Src2Value,
    output logic [15:0]           O_Imm,
    output logic                  O_DecodeStall,
    output logic                  O_BranchStallSignal,
    output logic                  O_DepStallSignal
);

    logic [DATA_WIDTH-1:0] regFile [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busyNext;
    logic [NUM_REGS-1:0]   wbClearMask;
    logic [NUM_REGS-1:0]   busyEff;
    br_state_e             brState;

    logic [OPCODE_W-1:0]   opcode;
    logic [REG_IDX_W-1:0]  destIdx;
    logic [REG_IDX_W-1:0]  src1Idx;
    logic [REG_IDX_W-1:0]  src2Idx;
    logic [IMM_W-1:0]      imm;
    logic [DATA_WIDTH-1:0] src1Val;
    logic [DATA_WIDTH-1:0] src2Val;

    logic usesSrc1;
    logic usesSrc2;
    logic writesDest;
    logic isBranch;
    logic validInst;
    logic hazard;
    logic issue;

    assign opcode  = I_IR[OPCODE_HI:OPCODE_LO];
    assign destIdx = I_IR[DEST_HI:DEST_LO];
    assign src1Idx = I_IR[SRC1_HI:SRC1_LO];
    assign src2Idx = I_IR[SRC2_HI:SRC2_LO];
    assign imm     = I_IR[IMM_HI:IMM_LO];

    decode_classify classify (
        .opcode     (opcode),
        .usesSrc1   (usesSrc1),
        .usesSrc2   (usesSrc2),
        .writesDest (writesDest),
        .isBranch   (isBranch)
    );

    // A register being written back this cycle is both forwarded and treated
    // as no longer in flight, so its consumer can issue in the same cycle.
    always_comb begin
        wbClearMask = '0;
        if (I_WBEnable) begin
            wbClearMask[I_WBDestReg] = 1'b1;
        end
        busyEff = busy & ~wbClearMask;
    end

    always_comb begin
        src1Val = regFile[src1Idx];
        src2Val = regFile[src2Idx];
        if (I_WBEnable && (I_WBDestReg == src1Idx)) begin
            src1Val = I_WBData;
        end
        if (I_WBEnable && (I_WBDestReg == src2Idx)) begin
            src2Val = I_WBData;
        end
    end

    always_comb begin
        validInst = I_LOCK && !I_FetchStall && (brState == BR_IDLE);
        hazard    = (usesSrc1 && busyEff[src1Idx])
                 || (usesSrc2 && busyEff[src2Idx])
                 || (writesDest && busyEff[destIdx]);
        issue            = validInst && !hazard;
        O_DepStallSignal = validInst && hazard;
    end

    // Writeback clear is applied first so a same-cycle issue to that register wins.
    always_comb begin
        busyNext = busyEff;
        if (issue && writesDest) begin
            busyNext[destIdx] = 1'b1;
        end
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= '0;
            end
            busy                <= '0;
            brState             <= BR_IDLE;
            O_BranchStallSignal <= 1'b0;
            O_LOCK              <= 1'b0;
            O_PC                <= '0;
            O_Opcode            <= OP_NOP;
            O_DestReg           <= '0;
            O_Src1Value         <= '0;
            O_Src2Value         <= '0;
            O_Imm               <= '0;
            O_DecodeStall       <= 1'b1;
        end else begin
            O_LOCK <= I_LOCK;
            if (!I_LOCK) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    regFile[i] <= '0;
                end
                busy                <= '0;
                brState             <= BR_IDLE;
                O_BranchStallSignal <= 1'b0;
                O_PC                <= '0;
                O_Opcode            <= OP_NOP;
                O_DestReg           <= '0;
                O_Src1Value         <= '0;
                O_Src2Value         <= '0;
                O_Imm               <= '0;
                O_DecodeStall       <= 1'b1;
            end else begin
                if (I_WBEnable) begin
                    regFile[I_WBDestReg] <= I_WBData;
                end
                busy <= busyNext;

                if (issue) begin
                    O_PC          <= I_PC;
                    O_Opcode      <= opcode;
                    O_DestReg     <= destIdx;
                    O_Src1Value   <= src1Val;
                    O_Src2Value   <= src2Val;
                    O_Imm         <= imm;
                    O_DecodeStall <= 1'b0;
                end else begin
                    O_Opcode      <= OP_NOP;
                    O_DecodeStall <= 1'b1;
                end

                case (brState)
                    BR_IDLE: begin
                        if (issue && isBranch) begin
                            brState             <= BR_WAIT;
                            O_BranchStallSignal <= 1'b1;
                        end
                    end
                    BR_WAIT: begin
                        if (I_BranchAddrSelect) begin
                            brState             <= BR_IDLE;
                            O_BranchStallSignal <= 1'b0;
                        end
                    end
                    default: begin
                        brState             <= BR_IDLE;
                        O_BranchStallSignal <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver queues hand-computed results
// per cycle, an independent monitor compares them after each negedge.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        lock;
    logic [15:0] pc;
    logic [31:0] ir;
    logic        fetchStall;
    logic        brSel;
    logic        wbEn;
    logic [3:0]  wbDest;
    logic [15:0] wbData;

    logic        oLock;
    logic [15:0] oPc;
    logic [7:0]  oOpcode;
    logic [3:0]  oDestReg;
    logic [15:0] oSrc1;
    logic [15:0] oSrc2;
    logic [15:0] oImm;
    logic        oDecodeStall;
    logic        oBranchStall;
    logic        oDepStall;

    decode_stage #(
        .NUM_REGS   (16),
        .DATA_WIDTH (16),
        .PC_WIDTH   (16),
        .IR_WIDTH   (32)
    ) dut (
        .I_CLOCK             (clk),
        .I_RESET             (rst),
        .I_LOCK              (lock),
        .I_PC                (pc),
        .I_IR                (ir),
        .I_FetchStall        (fetchStall),
        .I_BranchAddrSelect  (brSel),
        .I_WBEnable          (wbEn),
        .I_WBDestReg         (wbDest),
        .I_WBData            (wbData),
        .O_LOCK              (oLock),
        .O_PC                (oPc),
        .O_Opcode            (oOpcode),
        .O_DestReg           (oDestReg),
        .O_Src1Value         (oSrc1),
        .O_Src2Value         (oSrc2),
        .O_Imm               (oImm),
        .O_DecodeStall       (oDecodeStall),
        .O_BranchStallSignal (oBranchStall),
        .O_DepStallSignal    (oDepStall)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        dep;
        logic        stall;
        logic        br;
        logic [7:0]  op;
        logic [3:0]  dest;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [15:0] pc;
        logic [15:0] imm;
    } exp_t;

    exp_t q[$];
    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        nChecks++;
        if (act !== want) begin
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
        end else begin
            nPass++;
        end
    endtask

    task automatic drive(input logic [15:0] p, input logic [31:0] i, input logic fs,
                         input logic bs, input logic we, input logic [3:0] wd,
                         input logic [15:0] wdat);
        @(posedge clk);
        #1;
        pc         = p;
        ir         = i;
        fetchStall = fs;
        brSel      = bs;
        wbEn       = we;
        wbDest     = wd;
        wbData     = wdat;
    endtask

    task automatic expIssue(input logic [15:0] p, input logic [7:0] op, input logic [3:0] d,
                            input logic [15:0] s1, input logic [15:0] s2,
                            input logic [15:0] im, input logic br);
        exp_t e;
        e.dep = 1'b0; e.stall = 1'b0; e.br = br; e.op = op; e.dest = d;
        e.s1 = s1; e.s2 = s2; e.pc = p; e.imm = im;
        q.push_back(e);
    endtask

    task automatic expBubble(input logic dep, input logic br);
        exp_t e;
        e.dep = dep; e.stall = 1'b1; e.br = br; e.op = 8'hFF; e.dest = '0;
        e.s1 = '0; e.s2 = '0; e.pc = '0; e.imm = '0;
        q.push_back(e);
    endtask

    // Monitor: depStall sampled mid-cycle (before the negedge that consumes it),
    // registered outputs sampled just after that negedge.
    initial begin
        logic depS;
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            depS = oDepStall;
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("depStall", {31'b0, depS}, {31'b0, e.dep});
                chk("decodeStall", {31'b0, oDecodeStall}, {31'b0, e.stall});
                chk("opcode", {24'b0, oOpcode}, {24'b0, e.op});
                chk("branchStall", {31'b0, oBranchStall}, {31'b0, e.br});
                chk("lock", {31'b0, oLock}, 32'd1);
                if (!e.stall) begin
                    chk("pc", {16'b0, oPc}, {16'b0, e.pc});
                    chk("destReg", {28'b0, oDestReg}, {28'b0, e.dest});
                    chk("src1", {16'b0, oSrc1}, {16'b0, e.s1});
                    chk("src2", {16'b0, oSrc2}, {16'b0, e.s2});
                    chk("imm", {16'b0, oImm}, {16'b0, e.imm});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; lock = 1'b0; pc = '0; ir = '0; fetchStall = 1'b1;
        brSel = 1'b0; wbEn = 1'b0; wbDest = '0; wbData = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst decodeStall", {31'b0, oDecodeStall}, 32'd1);
        chk("rst opcode", {24'b0, oOpcode}, 32'hFF);
        chk("rst branchStall", {31'b0, oBranchStall}, 32'd0);
        chk("rst lock", {31'b0, oLock}, 32'd0);
        chk("rst pc", {16'b0, oPc}, 32'd0);
        chk("rst src1", {16'b0, oSrc1}, 32'd0);
        chk("rst depStall", {31'b0, oDepStall}, 32'd0);
        rst  = 1'b0;
        lock = 1'b1;

        // Preload r1=5, r2=7 through writeback.
        drive(16'd0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd1, 16'd5);       expBubble(1'b0, 1'b0);
        drive(16'd0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd2, 16'd7);       expBubble(1'b0, 1'b0);
        // ADD r3,r1,r2
        drive(16'd4, 32'h00310200, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        expIssue(16'd4, 8'h00, 4'd3, 16'd5, 16'd7, 16'h0200, 1'b0);
        // ADD r4,r3,r1 stalls on r3 until its writeback, then bypasses 0xAA.
        drive(16'd8, 32'h00430100, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0); expBubble(1'b1, 1'b0);
        drive(16'd8, 32'h00430100, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0); expBubble(1'b1, 1'b0);
        drive(16'd8, 32'h00430100, 1'b0, 1'b0, 1'b1, 4'd3, 16'h00AA);
        expIssue(16'd8, 8'h00, 4'd4, 16'h00AA, 16'd5, 16'h0100, 1'b0);
        // Fetch bubble carrying a write to r3 must not mark r3 busy.
        drive(16'd12, 32'h00310200, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0); expBubble(1'b0, 1'b0);
        drive(16'd16, 32'h00530300, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        expIssue(16'd16, 8'h00, 4'd5, 16'h00AA, 16'h00AA, 16'h0300, 1'b0);
        // ADDI r5 with same-cycle writeback of r5: issues, busy[5] stays set.
        drive(16'd20, 32'h01510010, 1'b0, 1'b0, 1'b1, 4'd5, 16'h0033);
        expIssue(16'd20, 8'h01, 4'd5, 16'd5, 16'd0, 16'h0010, 1'b0);
        drive(16'd24, 32'h00650100, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0); expBubble(1'b1, 1'b0);
        drive(16'd24, 32'h00650100, 1'b0, 1'b0, 1'b1, 4'd5, 16'h0044);
        expIssue(16'd24, 8'h00, 4'd6, 16'h0044, 16'd5, 16'h0100, 1'b0);
        // BRZ r1, then three dropped instructions (one would otherwise dep-stall on r6).
        drive(16'd28, 32'h80010000, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        expIssue(16'd28, 8'h80, 4'd0, 16'd5, 16'd0, 16'h0000, 1'b1);
        drive(16'd32, 32'h00710200, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0); expBubble(1'b0, 1'b1);
        drive(16'd36, 32'h00760100, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0); expBubble(1'b0, 1'b1);
        drive(16'd40, 32'h00710200, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0); expBubble(1'b0, 1'b1);
        drive(16'd44, 32'h00710200, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0); expBubble(1'b0, 1'b0);
        drive(16'd44, 32'h00710200, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        expIssue(16'd44, 8'h00, 4'd7, 16'd5, 16'd7, 16'h0200, 1'b0);
        // Dep stall on r7, then a branch, then reset while the branch stall is held.
        drive(16'd48, 32'h00870100, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0); expBubble(1'b1, 1'b0);
        drive(16'd52, 32'h80010000, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        expIssue(16'd52, 8'h80, 4'd0, 16'd5, 16'd0, 16'h0000, 1'b1);
        drive(16'd56, 32'h00870100, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0); expBubble(1'b0, 1'b1);

        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst branchStall", {31'b0, oBranchStall}, 32'd0);
        chk("midrst decodeStall", {31'b0, oDecodeStall}, 32'd1);
        chk("midrst opcode", {24'b0, oOpcode}, 32'hFF);
        chk("midrst depStall", {31'b0, oDepStall}, 32'd0);
        chk("midrst pc", {16'b0, oPc}, 32'd0);
        chk("midrst lock", {31'b0, oLock}, 32'd0);

        // Scoreboard and regfile were cleared: ADD r8,r7,r1 issues with zeros.
        @(posedge clk);
        #1;
        rst = 1'b0;
        pc  = 16'd60;
        expIssue(16'd60, 8'h00, 4'd8, 16'd0, 16'd0, 16'h0100, 1'b0);
        drive(16'd64, 32'h00980100, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0); expBubble(1'b1, 1'b0);
        drive(16'd64, 32'h00980100, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0); expBubble(1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("queue drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
